seg14_scan_ctrl: RTL
====================

Name: seg14_scan_ctrl

Overview:
Scan scheduler for the 12-digit, 14-segment multiplexed display driven by the user-area macros. It owns a double-buffered 12-entry glyph frame buffer and sequences the shared segment bus across digits. Each digit gets a programmable dwell time and a blanking gap between digits to suppress ghosting. A host (wishbone glue or a message generator) writes glyphs into a shadow buffer and requests an atomic swap, which takes effect only at a frame boundary.

Parameters:
NUM_DIGITS, 12, digits scanned per frame; sel width.
SEG_W, 14, segment pattern width.
DWELL_W, 16, width of the per-digit dwell counter and cfg_dwell.
BLANK_CYCLES, 2, cycles with sel=0 before each digit is driven (minimum 1).
SCROLL_W, 8, width of cfg_scroll_frames (optional feature only).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
vdd/vss  inout  1  power pins, present only under USE_POWER_PINS
enable  in  1  1 = scan; 0 = blank and idle
cfg_dwell  in  DWELL_W  cycles each digit is driven; 0 treated as 1
wr_en  in  1  shadow buffer write strobe
wr_addr  in  4  digit index 0..NUM_DIGITS-1; out-of-range writes ignored
wr_data  in  SEG_W  glyph pattern (bit 13 = seg a ... bit 0)
swap_req  in  1  level; request copy shadow->active at next frame boundary
swap_ack  out  1  one-cycle pulse when the copy is performed
frame_done  out  1  one-cycle pulse at end of last digit's DRIVE
sel  out  NUM_DIGITS  one-hot digit select, registered
segm  out  SEG_W  segment pattern, registered

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, sel=0, segm=0, swap_ack=0, frame_done=0, digit index 0, dwell and blank counters 0, both buffers all-zero (space), pending swap cleared.
- FSM: IDLE -> BLANK when enable=1. BLANK: sel=0, segm=0 for BLANK_CYCLES cycles -> DRIVE. DRIVE: sel=1<<idx, segm=active[idx] for max(cfg_dwell,1) cycles. At the end of DRIVE: if idx<NUM_DIGITS-1, idx++ and -> BLANK; else idx=0, frame_done pulses, -> BLANK.
- Outputs are registered: the first DRIVE cycle shows sel/segm on the cycle after the last BLANK cycle. Latency from enable rising to first sel!=0 is 1+BLANK_CYCLES cycles.
- cfg_dwell is sampled at each DRIVE entry; a change mid-digit applies from the next digit.
- enable=0 in any state: next cycle IDLE, sel=0, segm=0, idx=0. No frame_done is issued. A pending swap is retained.
- Writes: wr_en updates shadow[wr_addr] at the posedge. The active buffer is never written directly. wr_addr>=NUM_DIGITS is a no-op.
- Swap: swap_req is sampled into a pending flag. At the frame boundary (the cycle frame_done pulses), or in IDLE, a pending swap copies shadow->active, pulses swap_ack and clears the flag. The host holds swap_req until swap_ack; swap_req still high after swap_ack re-arms the request.
- A write in the same cycle as the copy: the copy uses the pre-write shadow; the write lands in shadow only.
- The new active contents are first visible on digit 0 of the next frame; a frame is never torn.

Optional Feature:
SEG14_SCROLL_EN: adds input cfg_scroll_frames[SCROLL_W-1:0] and a start offset register (reset 0). Every cfg_scroll_frames completed frames (0 = scroll off), offset = (offset+1) mod NUM_DIGITS. DRIVE shows active[(idx+offset) mod NUM_DIGITS]. A swap resets offset to 0. Without the macro: no port, offset fixed at 0, direct indexing.

Decomposition:
- Package seg14_pkg: SEG_W, NUM_DIGITS, FSM state enum (IDLE, BLANK, DRIVE), glyph constants (space, A-Z, 0-9 14-bit patterns).
- One sub-module: seg14_frame_buf, holding the shadow/active arrays with write, copy and read-mux. The FSM and counters stay in the top.

Test Plan:
1. Reset, enable=1, cfg_dwell=3, BLANK_CYCLES=2 -> sel first 0x001 at cycle 3 after enable, held 3 cycles, 2 blank cycles, then 0x002. frame_done every 12*(3+2)=60 cycles.
2. Write shadow[0..11]="GUSTAVOVF 13", swap_req=1 mid-frame -> swap_ack coincides with frame_done. Next frame segm@sel=0x001 is 14'b10111101000000 (G); the current frame is unchanged.
3. wr_en with wr_addr=12 and 15, then swap -> active contents unchanged at all 12 digits.
4. enable dropped during DRIVE of digit 5 -> next cycle sel=0, segm=0, no frame_done. Re-enable restarts at digit 0 after 2 blank cycles.
5. cfg_dwell=0 -> each digit driven exactly 1 cycle. rst_n=0 mid-frame -> outputs 0 next cycle and buffers cleared.
6. (SEG14_SCROLL_EN) cfg_scroll_frames=1 -> frame n shows active[(i+n) mod 12] on digit i. A swap resets the offset to 0.

Source files
------------

// File: rtl/seg14_pkg.sv
// ---------------------------------------------------------------------------
// seg14_pkg : shared sizes, scan FSM states and 14-segment glyph constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg14_pkg;

  localparam int NUM_DIGITS = 12;
  localparam int SEG_W      = 14;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Bit order [13:0] = a b c d e f g1 g2 h i j k l m
  localparam logic [SEG_W-1:0] GLYPH_SPACE = 14'b00000000000000;
  localparam logic [SEG_W-1:0] GLYPH_A     = 14'b11101111000000;
  localparam logic [SEG_W-1:0] GLYPH_B     = 14'b11110001010010;
  localparam logic [SEG_W-1:0] GLYPH_C     = 14'b10011100000000;
  localparam logic [SEG_W-1:0] GLYPH_D     = 14'b11110000010010;
  localparam logic [SEG_W-1:0] GLYPH_E     = 14'b10011111000000;
  localparam logic [SEG_W-1:0] GLYPH_F     = 14'b10001110000000;
  localparam logic [SEG_W-1:0] GLYPH_G     = 14'b10111101000000;
  localparam logic [SEG_W-1:0] GLYPH_H     = 14'b01101111000000;
  localparam logic [SEG_W-1:0] GLYPH_I     = 14'b10010000010010;
  localparam logic [SEG_W-1:0] GLYPH_J     = 14'b01111000000000;
  localparam logic [SEG_W-1:0] GLYPH_K     = 14'b00001110001001;
  localparam logic [SEG_W-1:0] GLYPH_L     = 14'b00011100000000;
  localparam logic [SEG_W-1:0] GLYPH_M     = 14'b01101100101000;
  localparam logic [SEG_W-1:0] GLYPH_N     = 14'b01101100100001;
  localparam logic [SEG_W-1:0] GLYPH_O     = 14'b11111100000000;
  localparam logic [SEG_W-1:0] GLYPH_P     = 14'b11001111000000;
  localparam logic [SEG_W-1:0] GLYPH_Q     = 14'b11111100000001;
  localparam logic [SEG_W-1:0] GLYPH_R     = 14'b11001111000001;
  localparam logic [SEG_W-1:0] GLYPH_S     = 14'b10110111000000;
  localparam logic [SEG_W-1:0] GLYPH_T     = 14'b10000000010010;
  localparam logic [SEG_W-1:0] GLYPH_U     = 14'b01111100000000;
  localparam logic [SEG_W-1:0] GLYPH_V     = 14'b00001100001100;
  localparam logic [SEG_W-1:0] GLYPH_W     = 14'b01101100000101;
  localparam logic [SEG_W-1:0] GLYPH_X     = 14'b00000000101101;
  localparam logic [SEG_W-1:0] GLYPH_Y     = 14'b00000000101010;
  localparam logic [SEG_W-1:0] GLYPH_Z     = 14'b10010000001100;
  localparam logic [SEG_W-1:0] GLYPH_0     = 14'b11111100001100;
  localparam logic [SEG_W-1:0] GLYPH_1     = 14'b01100000001000;
  localparam logic [SEG_W-1:0] GLYPH_2     = 14'b11011011000000;
  localparam logic [SEG_W-1:0] GLYPH_3     = 14'b11110001000000;
  localparam logic [SEG_W-1:0] GLYPH_4     = 14'b01100111000000;
  localparam logic [SEG_W-1:0] GLYPH_5     = 14'b10110111000000;
  localparam logic [SEG_W-1:0] GLYPH_6     = 14'b10111111000000;
  localparam logic [SEG_W-1:0] GLYPH_7     = 14'b11100000000000;
  localparam logic [SEG_W-1:0] GLYPH_8     = 14'b11111111000000;
  localparam logic [SEG_W-1:0] GLYPH_9     = 14'b11110111000000;

endpackage

`default_nettype wire

// File: rtl/seg14_frame_buf.sv
// ---------------------------------------------------------------------------
// seg14_frame_buf : double-buffered glyph store (shadow written by host,
// active copied atomically from shadow, combinational read of active)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg14_frame_buf
  import seg14_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_addr_i,
  input  logic [SEG_W-1:0] wr_data_i,
  input  logic             copy_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [SEG_W-1:0] rd_data_o
);

  logic [SEG_W-1:0] shadow_q [NUM_DIGITS];
  logic [SEG_W-1:0] active_q [NUM_DIGITS];
  logic             wr_hit_d;

  assign wr_hit_d = wr_en_i && (wr_addr_i < 4'(NUM_DIGITS));

  // The copy reads shadow_q before this edge's write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (copy_i) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (wr_hit_d) begin
        shadow_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = active_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/seg14_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg14_scan_ctrl : 12-digit 14-segment scan scheduler with blanking gaps
// and frame-boundary buffer swap. Macros: USE_POWER_PINS, SEG14_SCROLL_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg14_scan_ctrl
  import seg14_pkg::*;
#(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int SCROLL_W     = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic [DWELL_W-1:0]     cfg_dwell_i,
`ifdef SEG14_SCROLL_EN
  input  logic [SCROLL_W-1:0]    cfg_scroll_frames_i,
`endif
  input  logic                   wr_en_i,
  input  logic [3:0]             wr_addr_i,
  input  logic [SEG_W-1:0]       wr_data_i,
  input  logic                   swap_req_i,
  output logic                   swap_ack_o,
  output logic                   frame_done_o,
  output logic [NUM_DIGITS-1:0]  sel_o,
  output logic [SEG_W-1:0]       segm_o
);

  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLK_W-1:0]      BLK_LOAD = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DWELL_W-1:0]    dwell_q;
  logic [BLK_W-1:0]      blank_q;
  logic                  pending_q;
  logic                  swap_ack_q;
  logic                  frame_done_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [SEG_W-1:0]      segm_q;
  logic [IDX_W-1:0]      offset_q;

  logic                  frame_end_d;
  logic                  copy_d;
  logic [DWELL_W-1:0]    dwell_load_d;
  logic [IDX_W:0]        rd_sum_d;
  logic [IDX_W-1:0]      rd_idx_d;
  logic [SEG_W-1:0]      rd_data_d;

  assign frame_end_d  = enable_i && (state_q == DRIVE) && (dwell_q == '0) && (idx_q == IDX_LAST);
  assign copy_d       = pending_q && (frame_end_d || (state_q == IDLE));
  assign dwell_load_d = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - 1'b1;
  assign rd_sum_d     = {1'b0, idx_q} + {1'b0, offset_q};
  assign rd_idx_d     = (rd_sum_d >= (IDX_W+1)'(NUM_DIGITS))
                      ? IDX_W'(rd_sum_d - (IDX_W+1)'(NUM_DIGITS))
                      : rd_sum_d[IDX_W-1:0];

  seg14_frame_buf u_frame_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .copy_i    (copy_d),
    .rd_idx_i  (rd_idx_d),
    .rd_data_o (rd_data_d)
  );

`ifdef SEG14_SCROLL_EN
  logic [SCROLL_W-1:0] frames_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset_q <= '0;
      frames_q <= '0;
    end else if (copy_d) begin
      offset_q <= '0;
      frames_q <= '0;
    end else if (frame_end_d && (cfg_scroll_frames_i != '0)) begin
      if (frames_q >= cfg_scroll_frames_i - 1'b1) begin
        frames_q <= '0;
        offset_q <= (offset_q == IDX_LAST) ? '0 : offset_q + 1'b1;
      end else begin
        frames_q <= frames_q + 1'b1;
      end
    end
  end
`else
  assign offset_q = '0;
`endif

  // A swap request raised on the copy edge is ignored so a held request
  // re-arms only from the cycle swap_ack is visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dwell_q      <= '0;
      blank_q      <= '0;
      pending_q    <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sel_q        <= '0;
      segm_q       <= '0;
    end else begin
      frame_done_q <= 1'b0;
      swap_ack_q   <= copy_d;
      if (copy_d) begin
        pending_q <= 1'b0;
      end else if (swap_req_i) begin
        pending_q <= 1'b1;
      end

      if (!enable_i) begin
        state_q <= IDLE;
        idx_q   <= '0;
        dwell_q <= '0;
        blank_q <= '0;
        sel_q   <= '0;
        segm_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= BLANK;
            blank_q <= BLK_LOAD;
          end
          BLANK: begin
            if (blank_q == '0) begin
              state_q <= DRIVE;
              dwell_q <= dwell_load_d;
              sel_q   <= SEL_ONE << idx_q;
              segm_q  <= rd_data_d;
            end else begin
              blank_q <= blank_q - 1'b1;
            end
          end
          DRIVE: begin
            if (dwell_q == '0) begin
              state_q <= BLANK;
              blank_q <= BLK_LOAD;
              sel_q   <= '0;
              segm_q  <= '0;
              if (idx_q == IDX_LAST) begin
                idx_q        <= '0;
                frame_done_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              dwell_q <= dwell_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign swap_ack_o   = swap_ack_q;
  assign frame_done_o = frame_done_q;
  assign sel_o        = sel_q;
  assign segm_o       = segm_q;

endmodule

`default_nettype wire
